// File: rtl/if_pkg.sv
// Shared widths, fetch alignment and the prefetch buffer entry layout for the fetch stage.
package if_pkg;

   localparam int IF_ADDR_W     = 32;
   localparam int IF_INSTR_W    = 32;
   localparam int IF_FIFO_DEPTH = 4;
   localparam int IF_ALIGN      = 4;

   typedef struct packed {
      logic [IF_ADDR_W-1:0]  pc;
      logic [IF_INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Counters must hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/if_prefetch_stage_if.sv
// Instruction memory request/response bus between the prefetch stage (master) and memory (slave).
interface if_prefetch_stage_if
   import if_pkg::*;
#(
   parameter int ADDR_W  = IF_ADDR_W,
   parameter int INSTR_W = IF_INSTR_W
) ();

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_gnt;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/if_fetch_fifo.sv
// Prefetch buffer: power-of-two circular FIFO with synchronous clear; caller guarantees no overflow/underflow.
module if_fetch_fifo
   import if_pkg::*;
#(
   parameter int WIDTH = IF_ADDR_W + IF_INSTR_W,
   parameter int DEPTH = IF_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic                          clear,
   input  logic [WIDTH-1:0]              push_data,
   output logic [WIDTH-1:0]              pop_data,
   output logic                          full,
   output logic                          empty,
   output logic [cnt_width(DEPTH)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction prefetch stage: credit-limited fetch into a small buffer with branch redirect and stale-response discard.
// Optional IF_PERF_CNT_EN adds a saturating stall_cnt output.
module if_prefetch_stage
   import if_pkg::*;
#(
   parameter int                ADDR_W     = IF_ADDR_W,
   parameter int                INSTR_W    = IF_INSTR_W,
   parameter int                FIFO_DEPTH = IF_FIFO_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 freeze,
   input  logic                 branch_taken,
   input  logic [ADDR_W-1:0]    branch_address,
   if_prefetch_stage_if.master  imem,
   output logic                 out_valid,
   output logic [INSTR_W-1:0]   instruction_out,
   output logic [ADDR_W-1:0]    next_pc
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]          stall_cnt
`endif
);

   localparam int CNT_W   = cnt_width(FIFO_DEPTH);
   localparam int ENTRY_W = ADDR_W + INSTR_W;

   logic [ADDR_W-1:0]  fetch_pc;
   logic [ADDR_W-1:0]  resp_pc;
   logic [ADDR_W-1:0]  branch_pc;
   logic [CNT_W-1:0]   outstanding;
   logic [CNT_W-1:0]   discard_cnt;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W:0]     credit_used;
   logic               accept;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] head;

   assign branch_pc   = branch_address & ~ADDR_W'(IF_ALIGN - 1);
   assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};

   // Gating with rst keeps the request low while in reset and lets it rise as soon as reset releases.
   assign imem.imem_req  = rst & ~branch_taken & (credit_used < (CNT_W+1)'(FIFO_DEPTH));
   assign imem.imem_addr = fetch_pc;
   assign accept         = imem.imem_req & imem.imem_gnt;

   assign pop  = ~fifo_empty & ~freeze & ~branch_taken;
   assign push = imem.imem_rvalid & (discard_cnt == '0) & ~branch_taken & (~fifo_full | pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard_cnt <= '0;
      end else begin
         outstanding <= outstanding + CNT_W'(accept) - CNT_W'(imem.imem_rvalid);
         if (branch_taken) begin
            fetch_pc    <= branch_pc;
            resp_pc     <= branch_pc;
            // Everything still in flight belongs to the old path.
            discard_cnt <= outstanding - CNT_W'(imem.imem_rvalid);
         end else begin
            if (accept) fetch_pc <= fetch_pc + ADDR_W'(IF_ALIGN);
            if (imem.imem_rvalid) begin
               if (discard_cnt != '0) discard_cnt <= discard_cnt - CNT_W'(1);
               else                   resp_pc     <= resp_pc + ADDR_W'(IF_ALIGN);
            end
         end
      end
   end

   if_fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .clear     (branch_taken),
      .push_data ({resp_pc, imem.imem_rdata}),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign out_valid       = ~fifo_empty;
   assign instruction_out = head[INSTR_W-1:0];
   assign next_pc         = head[ENTRY_W-1:INSTR_W] + ADDR_W'(IF_ALIGN);

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (!out_valid && !branch_taken && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Scoreboard bench for if_prefetch_stage with a behavioural in-order instruction memory.
module tb_if_prefetch_stage;
   import if_pkg::*;

   localparam int AW = 32;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          freeze = 1'b0;
   logic          branch_taken = 1'b0;
   logic [AW-1:0] branch_address = '0;
   logic          out_valid;
   logic [IW-1:0] instruction_out;
   logic [AW-1:0] next_pc;
`ifdef IF_PERF_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   if_prefetch_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) imem ();

   if_prefetch_stage #(
      .ADDR_W     (AW),
      .INSTR_W    (IW),
      .FIFO_DEPTH (4),
      .RESET_PC   (32'h0)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .freeze          (freeze),
      .branch_taken    (branch_taken),
      .branch_address  (branch_address),
      .imem            (imem),
      .out_valid       (out_valid),
      .instruction_out (instruction_out),
      .next_pc         (next_pc)
`ifdef IF_PERF_CNT_EN
      ,
      .stall_cnt       (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int pops     = 0;
   int acc_cnt  = 0;
   int cyc      = 0;
   int gnt_mode = 0;   // 0 always grant, 1 withhold, 2 random
   int lat_mode = 0;   // 0 zero-wait, 1 long fixed, 2 random 0-3 extra

   fetch_entry_t  exp_q[$];
   fetch_entry_t  mon_e;
   logic [AW-1:0] pend_addr[$];
   int            pend_due[$];
   int            due;

   function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
      return a ^ 32'hA5C3_0F1E ^ {a[15:0], 16'h0};
   endfunction

   function automatic int lat_extra();
      case (lat_mode)
         1:       return 10;
         2:       return int'($urandom_range(0, 3));
         default: return 0;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic push_seq(input logic [AW-1:0] start, input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         fetch_entry_t e;
         e.pc    = start + AW'(4 * i);
         e.instr = mem_data(e.pc);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_out_valid(input string name, input int lim);
      int k = 0;
      while (!out_valid && k < lim) begin
         @(negedge clk); #1;
         k++;
      end
      check({name, "_timeout"}, 64'(out_valid), 64'(1));
   endtask

   // Memory: accepted requests become due at least one cycle later, delivered in order.
   always @(posedge clk) begin
      if (!rst) begin
         pend_addr.delete();
         pend_due.delete();
      end else begin
         if (imem.imem_rvalid && pend_due.size() > 0) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
         if (imem.imem_req && imem.imem_gnt) begin
            due = cyc + 1 + lat_extra();
            if (pend_due.size() > 0 && due < pend_due[$]) due = pend_due[$];
            pend_addr.push_back(imem.imem_addr);
            pend_due.push_back(due);
            acc_cnt++;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      case (gnt_mode)
         1:       imem.imem_gnt = 1'b0;
         2:       imem.imem_gnt = 1'($urandom_range(0, 1));
         default: imem.imem_gnt = 1'b1;
      endcase
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
         imem.imem_rvalid = 1'b1;
         imem.imem_rdata  = mem_data(pend_addr[0]);
      end else begin
         imem.imem_rvalid = 1'b0;
         imem.imem_rdata  = '0;
      end
   end

   // Monitor: every entry the stage hands downstream must be the next expected one.
   always @(negedge clk) begin
      #1;
      if (rst && out_valid && !freeze && !branch_taken) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 64'(1), 64'(0));
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_next_pc", 64'(next_pc), 64'(mon_e.pc + 32'd4));
            check("sb_instr", 64'(instruction_out), 64'(mon_e.instr));
            pops++;
         end
      end
   end

   initial begin
      int hi;
      int p0;

      // Reset state
      repeat (2) @(negedge clk); #1;
      check("rst_imem_req", 64'(imem.imem_req), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_imem_addr", 64'(imem.imem_addr), 64'(0));

      // Zero-wait streaming from reset
      @(negedge clk);
      push_seq(32'h0, 400);
      rst = 1'b1;
      #1;
      check("first_req", 64'(imem.imem_req), 64'(1));
      check("addr_c0", 64'(imem.imem_addr), 64'(0));
      check("out_valid_c0", 64'(out_valid), 64'(0));
      @(negedge clk); #1;
      check("addr_c1", 64'(imem.imem_addr), 64'(4));
      check("out_valid_c1", 64'(out_valid), 64'(0));
      @(negedge clk); #1;
      check("out_valid_c2", 64'(out_valid), 64'(1));
      check("next_pc_c2", 64'(next_pc), 64'(4));
      check("addr_c2", 64'(imem.imem_addr), 64'(8));
      hi = 0;
      repeat (20) begin
         @(negedge clk); #1;
         if (out_valid) hi++;
      end
      check("throughput", 64'(hi), 64'(20));

      // Freeze from reset: credits cap requests at the buffer depth
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      freeze = 1'b1;
      repeat (2) @(negedge clk);
      acc_cnt = 0;
      push_seq(32'h0, 400);
      rst = 1'b1;
      repeat (5) @(negedge clk); #1;
      check("freeze_head_mid", 64'(next_pc), 64'(4));
      @(negedge clk);
      repeat (5) @(negedge clk); #1;
      check("freeze_req_count", 64'(acc_cnt), 64'(4));
      check("freeze_req_low", 64'(imem.imem_req), 64'(0));
      check("freeze_head_pc", 64'(next_pc), 64'(4));
      check("freeze_head_instr", 64'(instruction_out), 64'(mem_data(32'h0)));
      @(negedge clk);
      freeze = 1'b0;
      p0 = pops;
      repeat (20) @(negedge clk);
      check("freeze_drain", 64'(pops - p0 >= 8), 64'(1));

      // Branch with three responses in flight, unaligned target
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      lat_mode = 1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      branch_taken   = 1'b1;
      branch_address = 32'h0000_0103;
      push_seq(32'h100, 400);
      #1;
      check("branch_req_low", 64'(imem.imem_req), 64'(0));
      check("branch_out_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
      lat_mode = 0;
      @(negedge clk);
      branch_taken = 1'b0;
      #1;
      check("branch_addr_aligned", 64'(imem.imem_addr), 64'h100);
      check("branch_req_high", 64'(imem.imem_req), 64'(1));
      wait_out_valid("branch_first", 40);
      check("branch_first_pc", 64'(next_pc), 64'h104);
      check("branch_first_instr", 64'(instruction_out), 64'(mem_data(32'h100)));
      repeat (12) @(negedge clk);

      // Grant withheld for five cycles right after a redirect
      @(posedge clk); #1;
      gnt_mode = 1;
      @(negedge clk);
      branch_taken   = 1'b1;
      branch_address = 32'h0000_0400;
      push_seq(32'h400, 400);
      @(negedge clk);
      branch_taken = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("withhold_addr", 64'(imem.imem_addr), 64'h400);
         check("withhold_req", 64'(imem.imem_req), 64'(1));
         if (i == 4) begin
            @(posedge clk); #1;
            gnt_mode = 0;
         end
         @(negedge clk);
      end
      wait_out_valid("withhold_resume", 20);
      check("withhold_first_pc", 64'(next_pc), 64'h404);
      repeat (15) @(negedge clk);

      // Random grant, latency and freeze with back-to-back redirects
      @(posedge clk); #1;
      gnt_mode = 2;
      lat_mode = 2;
      p0 = pops;
      for (int c = 0; c < 240; c++) begin
         @(negedge clk);
         freeze = ($urandom_range(0, 3) == 0);
         if (c == 120) begin
            branch_taken   = 1'b1;
            branch_address = 32'h0000_0200;
            push_seq(32'h200, 400);
         end else if (c == 121) begin
            branch_taken   = 1'b1;
            branch_address = 32'h0000_0302;
            push_seq(32'h300, 400);
         end else begin
            branch_taken = 1'b0;
         end
      end
      @(negedge clk);
      freeze = 1'b0;
      branch_taken = 1'b0;
      @(posedge clk); #1;
      gnt_mode = 0;
      lat_mode = 0;
      repeat (20) @(negedge clk); #1;
      check("random_progress", 64'(pops - p0 >= 30), 64'(1));
      check("random_resumed", 64'(out_valid), 64'(1));

`ifdef IF_PERF_CNT_EN
      // Stall counter: two start-up cycles plus a seven-cycle grant gap
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      push_seq(32'h0, 400);
      rst = 1'b1;
      repeat (9) @(negedge clk); #1;
      check("stall_cnt_startup", 64'(stall_cnt), 64'(2));
      @(posedge clk); #1;
      gnt_mode = 1;
      @(negedge clk);
      repeat (6) @(negedge clk);
      @(posedge clk); #1;
      gnt_mode = 0;
      repeat (10) @(negedge clk); #1;
      check("stall_cnt_gap", 64'(stall_cnt), 64'(9));
`endif

      // Asynchronous reset in mid-stream clears everything at once
      @(negedge clk);
      #2;
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_req", 64'(imem.imem_req), 64'(0));
      check("midrst_addr", 64'(imem.imem_addr), 64'(0));
`ifdef IF_PERF_CNT_EN
      check("midrst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
      repeat (2) @(negedge clk);
      push_seq(32'h0, 400);
      rst = 1'b1;
      #1;
      check("midrst_restart_addr", 64'(imem.imem_addr), 64'(0));
      wait_out_valid("midrst_restart", 10);
      check("midrst_restart_pc", 64'(next_pc), 64'(4));
      repeat (10) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/if_prefetch_stage.md
IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- ADDR_W, 32, address width
- INSTR_W, 32, instruction width
- FIFO_DEPTH, 4, prefetch buffer entries (power of 2, >= 2)
- RESET_PC, 0, fetch address after reset

REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock
- rst, in, 1, reset: asynchronous, active-low
- freeze, in, 1, downstream stall; holds output entry
- branch_taken, in, 1, redirect request
- branch_address, in, ADDR_W, redirect target
- imem_req, out, 1, fetch request valid
- imem_addr, out, ADDR_W, fetch address
- imem_gnt, in, 1, memory accepts request this cycle
- imem_rvalid, in, 1, in-order response valid
- imem_rdata, in, INSTR_W, response data
- out_valid, out, 1, instruction_out/next_pc valid
- instruction_out, out, INSTR_W, head instruction
- next_pc, out, ADDR_W, head entry PC + 4

Function
REQ-003 fetch_pc register SHALL hold the next address to request; imem_addr = fetch_pc.
REQ-004 imem_req SHALL be 1 iff (outstanding + fifo_count) < FIFO_DEPTH and branch_taken = 0.
REQ-005 A request is accepted on the edge where imem_req & imem_gnt; fetch_pc += 4 (mod 2^ADDR_W, wraps silently); outstanding += 1.
REQ-006 While imem_req = 1 and imem_gnt = 0, imem_addr SHALL stay stable; imem_req deasserts only on branch_taken.
REQ-007 Responses SHALL arrive no earlier than the cycle after acceptance, in order; each imem_rvalid decrements outstanding.
REQ-008 On imem_rvalid with discard_cnt = 0, {pc, imem_rdata} SHALL be pushed into the FIFO; with discard_cnt > 0, the response is dropped and discard_cnt -= 1.
REQ-009 out_valid = FIFO non-empty; instruction_out/next_pc come from the head entry; the head pops on the edge where out_valid & !freeze.
REQ-010 Push and pop in the same cycle SHALL leave the count unchanged; overflow is impossible by REQ-004 credit rule.
REQ-011 freeze SHALL NOT stop fetching; requests continue until credits are exhausted.
REQ-012 branch_taken cycle: FIFO cleared; fetch_pc <= {branch_address[ADDR_W-1:2], 2'b00}; discard_cnt <= outstanding - imem_rvalid; no pop; no push.
REQ-013 Back-to-back branch_taken: the last one wins; discard accounting remains exact.
REQ-014 Zero-wait memory latency: request accepted cycle N, rvalid N+1, out_valid N+2; sustained throughput is 1 instruction/cycle.

Reset
REQ-015 rst = 0 SHALL asynchronously set fetch_pc = RESET_PC, FIFO empty, outstanding = 0, discard_cnt = 0, out_valid = 0, imem_req = 0, counters = 0.
REQ-016 Reset mid-transaction: in-flight responses are abandoned; memory is reset alongside.
REQ-017 First imem_req SHALL assert in the first cycle after rst deasserts.

Configuration
REQ-018 Macro IF_PERF_CNT_EN defined: adds output stall_cnt (32-bit), which increments each cycle with out_valid = 0 and branch_taken = 0, saturates at all-ones, and is reset to 0.
REQ-019 IF_PERF_CNT_EN undefined: no stall_cnt port and no counter logic.

Structure
REQ-020 Shared package if_pkg SHALL hold the default widths, the instruction alignment constant (4), and the fetch entry struct {pc, instr}.
REQ-021 The FIFO SHALL be a sub-module if_fetch_fifo (parameters: width, depth; ports: push, pop, clear, full, empty, count).
REQ-022 Credit and discard counters SHALL be ceil(log2(FIFO_DEPTH+1)) bits.

Verification
REQ-023 Reset, zero-wait memory, freeze = 0 -> imem_addr 0, 4, 8, ...; out_valid from cycle 2; next_pc = 4, 8, 12, ...
REQ-024 freeze = 1 held 10 cycles, DEPTH = 4 -> exactly 4 requests issued, then imem_req = 0; head unchanged; release drains in order.
REQ-025 3 outstanding, branch_taken to 0x100 -> next 3 rvalid dropped; first out entry has next_pc = 0x104.
REQ-026 branch_address = 0x103 -> imem_addr = 0x100.
REQ-027 gnt withheld 5 cycles -> imem_addr stable; random gnt/rvalid latency 0-3 -> stream in order, no loss.
REQ-028 IF_PERF_CNT_EN defined, memory stalls 7 cycles -> stall_cnt += 7; rst = 0 mid-stream -> all state cleared immediately.
